// File: rtl/addsub_pkg.sv
// ============================================================================
// Module      : addsub_pkg
// Description : Shared constants, FSM state type and parity helper for addsub_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package addsub_pkg;

  localparam int FLG_AF = 5;
  localparam int FLG_CF = 4;
  localparam int FLG_OF = 3;
  localparam int FLG_ZF = 2;
  localparam int FLG_SF = 1;
  localparam int FLG_PF = 0;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // 8088 PF: set when the low byte holds an even number of ones
  function automatic logic even_parity8(input logic [7:0] v);
    return ~^v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/addsub_slice.sv
// ============================================================================
// Module      : addsub_slice
// Description : Combinational SLICE-bit ripple adder; operand B arrives pre-inverted.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_slice
  import addsub_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic             i_cin,
  output logic [SLICE-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb,
  output logic             o_c3
);

  logic [SLICE:0] w_c;

  always_comb begin
    w_c    = '0;
    o_sum  = '0;
    w_c[0] = i_cin;
    for (int k = 0; k < SLICE; k++) begin
      o_sum[k]  = i_a[k] ^ i_b[k] ^ w_c[k];
      w_c[k+1]  = (i_a[k] & i_b[k]) | (w_c[k] & (i_a[k] ^ i_b[k]));
    end
  end

  assign o_cout = w_c[SLICE];
  assign o_cmsb = w_c[SLICE-1];
  assign o_c3   = w_c[4];

endmodule

`default_nettype wire

// File: rtl/addsub_seq.sv
// ============================================================================
// Module      : addsub_seq
// Description : Multi-cycle add/subtract, SLICE bits per clock, 8088 flag set.
//               Optional ADDSUB_SAT_EN adds a sat port for signed clamping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic             cin,
`ifdef ADDSUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic [5:0]       flags
);

  localparam int c_NSL  = WIDTH / SLICE;
  localparam int c_IDXW = (c_NSL > 1) ? $clog2(c_NSL) : 1;
  localparam logic [c_IDXW-1:0] c_LAST = c_IDXW'(c_NSL - 1);

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_op;
  logic              r_carry;
  logic              r_af;
  logic [c_IDXW-1:0] r_idx;
  logic [WIDTH-1:0]  r_r;
  logic [5:0]        r_flags;
`ifdef ADDSUB_SAT_EN
  logic              r_sat;
`endif

  logic [SLICE-1:0] w_sl_a;
  logic [SLICE-1:0] w_sl_b;
  logic [SLICE-1:0] w_sum;
  logic             w_cout;
  logic             w_cmsb;
  logic             w_c3;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_fin;
  logic             w_af;
  logic             w_of;
  logic [5:0]       w_flags;

  assign w_sl_a = r_a[r_idx*SLICE +: SLICE];
  assign w_sl_b = r_b[r_idx*SLICE +: SLICE];

  addsub_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .i_a    (w_sl_a),
    .i_b    (w_sl_b),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_cmsb (w_cmsb),
    .o_c3   (w_c3)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = RUN;
        end
      end
      RUN: begin
        if (r_idx == c_LAST) begin
          w_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Final-slice view: upper slice comes straight from the adder this cycle
  always_comb begin
    w_res                    = r_r;
    w_res[WIDTH-1 -: SLICE]  = w_sum;
    w_af                     = (r_idx == '0) ? w_c3 : r_af;
    w_of                     = w_cmsb ^ w_cout;
    w_fin                    = w_res;
`ifdef ADDSUB_SAT_EN
    if (r_sat && w_of) begin
      w_fin = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    w_flags         = '0;
    w_flags[FLG_AF] = w_af ^ r_op;
    w_flags[FLG_CF] = w_cout ^ r_op;
    w_flags[FLG_OF] = w_of;
    w_flags[FLG_ZF] = (w_fin == '0);
    w_flags[FLG_SF] = w_fin[WIDTH-1];
    w_flags[FLG_PF] = even_parity8(w_fin[7:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= 1'b0;
      r_carry <= 1'b0;
      r_af    <= 1'b0;
      r_idx   <= '0;
      r_r     <= '0;
      r_flags <= '0;
`ifdef ADDSUB_SAT_EN
      r_sat   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b ^ {WIDTH{op}};
            r_op    <= op;
            r_carry <= cin ^ (op == OP_SUB);
            r_idx   <= '0;
`ifdef ADDSUB_SAT_EN
            r_sat   <= sat;
`endif
          end
        end
        RUN: begin
          r_carry <= w_cout;
          if (r_idx == '0) begin
            r_af <= w_c3;
          end
          if (r_idx == c_LAST) begin
            r_r     <= w_fin;
            r_flags <= w_flags;
          end else begin
            r_r[r_idx*SLICE +: SLICE] <= w_sum;
            r_idx                     <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign r     = r_r;
  assign flags = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_addsub_seq.sv
// ============================================================================
// Module      : tb_addsub_seq
// Description : Self-checking bench for addsub_seq (WIDTH=16, SLICE=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_addsub_seq;

  localparam int NSL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        op = 1'b0;
  logic        cin = 1'b0;
`ifdef ADDSUB_SAT_EN
  logic        sat = 1'b0;
`endif
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] r;
  logic [5:0]  flags;

  int checks = 0;
  int errors = 0;

  addsub_seq #(.WIDTH(16), .SLICE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .cin       (cin),
`ifdef ADDSUB_SAT_EN
    .sat       (sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, flags from their architectural meaning
  task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic mop,
                       input logic mcin, input logic msat,
                       output logic [15:0] er, output logic [5:0] ef);
    int unsigned ua, ub, full, lo;
    int sa, sb, s;
    logic [15:0] res;
    logic cf, af, of;
    ua   = ma;
    ub   = mop ? (~mb & 16'hFFFF) : mb;
    full = ua + ub + (mcin ? 1 : 0);
    lo   = (ua & 15) + (ub & 15) + (mcin ? 1 : 0);
    if (mop) begin
      // a - b - cin expressed as a + ~b + !cin
      full = ua + ub + (mcin ? 0 : 1);
      lo   = (ua & 15) + (ub & 15) + (mcin ? 0 : 1);
    end
    cf  = (full > 32'hFFFF) ^ mop;
    af  = (lo > 15) ^ mop;
    sa  = $signed(ma);
    sb  = mop ? -int'($signed(mb)) - (mcin ? 1 : 0) : int'($signed(mb)) + (mcin ? 1 : 0);
    s   = sa + sb;
    of  = (s > 32767) || (s < -32768);
    res = full[15:0];
    if (msat && of) res = ma[15] ? 16'h8000 : 16'h7FFF;
    er = res;
    ef = {af, cf, of, (res == 16'h0), res[15], ~^res[7:0]};
  endtask

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic iop,
                       input logic icin, input logic isat, output bit ok);
    @(negedge clk);
    a = ia; b = ib; op = iop; cin = icin;
`ifdef ADDSUB_SAT_EN
    sat = isat;
`endif
    in_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (in_ready) begin
        @(posedge clk);
        ok = 1;
      end else begin
        @(negedge clk);
      end
    end
    #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); op = 1'($urandom); cin = 1'($urandom);
`ifdef ADDSUB_SAT_EN
    sat = ~isat;
`endif
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    checks++;
    if (r !== 16'h0 || flags !== 6'h0) begin
      errors++;
      $display("FAIL reset_data: r=%h flags=%b required 0000/000000", r, flags);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] va[4] = '{16'h7FFF, 16'h0000, 16'hFFFF, 16'h1234};
    logic [15:0] vb[4] = '{16'h0001, 16'h0001, 16'h0001, 16'h1234};
    logic        vo[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic        vc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] vr[4] = '{16'h8000, 16'hFFFF, 16'h0000, 16'hFFFF};
    logic [5:0]  vf[4] = '{6'b101011, 6'b110011, 6'b110101, 6'b110011};
    bit ok;
    int lat;
    for (int i = 0; i < 4; i++) begin
      issue(va[i], vb[i], vo[i], vc[i], 1'b0, ok);
      wait_out(lat);
      checks++;
      if (!ok || lat != NSL) begin
        errors++;
        $display("FAIL dir_latency[%0d]: accepted=%0d latency=%0d required 1/%0d", i, ok, lat, NSL);
      end
      checks++;
      if (r !== vr[i] || flags !== vf[i]) begin
        errors++;
        $display("FAIL dir_result[%0d]: r=%h flags=%b required %h/%b", i, r, flags, vr[i], vf[i]);
      end
      release_out();
    end
  endtask

  task automatic test_random();
    logic [15:0] ra, rb, er;
    logic [5:0]  ef;
    logic        rop, rc, rs;
    bit ok;
    int lat;
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rop = 1'($urandom); rc = 1'($urandom);
`ifdef ADDSUB_SAT_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      if (i % 8 == 0) rb = ra;
      model(ra, rb, rop, rc, rs, er, ef);
      issue(ra, rb, rop, rc, rs, ok);
      wait_out(lat);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      checks++;
      if (!ok || lat != NSL || r !== er || flags !== ef) begin
        errors++;
        $display("FAIL rand[%0d] %h op%0d %h c%0d s%0d: lat=%0d r=%h flags=%b required lat=%0d r=%h flags=%b",
                 i, ra, rop, rb, rc, rs, lat, r, flags, NSL, er, ef);
      end
      release_out();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] hr, er;
    logic [5:0]  hf, ef;
    bit ok;
    int lat;
    issue(16'hA5A5, 16'h5A5B, 1'b0, 1'b1, 1'b0, ok);
    wait_out(lat);
    hr = r; hf = flags;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (r !== hr || flags !== hf || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold[%0d]: r=%h flags=%b in_ready=%b out_valid=%b required %h/%b/0/1",
                 i, r, flags, in_ready, out_valid, hr, hf);
      end
    end
    model(16'h8001, 16'h0002, 1'b1, 1'b0, 1'b0, er, ef);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; a = 16'h8001; b = 16'h0002; op = 1'b1; cin = 1'b0;
`ifdef ADDSUB_SAT_EN
    sat = 1'b0;
`endif
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = 16'hFFFF; b = 16'hFFFF;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: in_ready=%b required 0", in_ready);
    end
    wait_out(lat);
    checks++;
    if (lat != NSL || r !== er || flags !== ef) begin
      errors++;
      $display("FAIL b2b_result: lat=%0d r=%h flags=%b required %0d/%h/%b", lat, r, flags, NSL, er, ef);
    end
    release_out();
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] er;
    logic [5:0]  ef;
    bit ok;
    bit seen;
    int lat;
    issue(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, ok);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || r !== 16'h0 || flags !== 6'h0) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%b in_ready=%b r=%h flags=%b required 0/1/0000/000000",
               out_valid, in_ready, r, flags);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mid_reset_drop: out_valid=1 required 0 after aborted op");
    end
    model(16'h4321, 16'h1234, 1'b1, 1'b1, 1'b0, er, ef);
    issue(16'h4321, 16'h1234, 1'b1, 1'b1, 1'b0, ok);
    wait_out(lat);
    checks++;
    if (!ok || lat != NSL || r !== er || flags !== ef) begin
      errors++;
      $display("FAIL post_reset: lat=%0d r=%h flags=%b required %0d/%h/%b", lat, r, flags, NSL, er, ef);
    end
    release_out();
  endtask

`ifdef ADDSUB_SAT_EN
  task automatic test_sat();
    bit ok;
    int lat;
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, ok);
    wait_out(lat);
    checks++;
    if (lat != NSL || r !== 16'h7FFF || flags !== 6'b101001) begin
      errors++;
      $display("FAIL sat_pos: lat=%0d r=%h flags=%b required %0d/7fff/101001", lat, r, flags, NSL);
    end
    release_out();
    issue(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1, ok);
    wait_out(lat);
    checks++;
    if (lat != NSL || r !== 16'h8000 || flags !== 6'b101011) begin
      errors++;
      $display("FAIL sat_neg: lat=%0d r=%h flags=%b required %0d/8000/101011", lat, r, flags, NSL);
    end
    release_out();
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
`ifdef ADDSUB_SAT_EN
    test_sat();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
- Parametrised, multi-cycle add/subtract unit for the 8088 ALU datapath.
- Successor to the fixed 16-bit ripple adder. It supports any WIDTH and processes SLICE bits per clock, carrying between cycles.
- Operands are accepted and results delivered over valid/ready handshakes.
- Produces the full 8088 arithmetic flag set: AF, CF, OF, ZF, SF, PF.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SLICE and at least 8.
- SLICE, 4, bits added per clock; must be at least 4; NSL = WIDTH/SLICE cycles per operation.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operand request valid.
- in_ready  output  1  unit can accept an operand request.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  1  0 = add, 1 = subtract.
- cin  input  1  carry-in for add, borrow-in for subtract (ADC/SBB); 0 for plain ADD/SUB.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- r  output  WIDTH  result.
- flags  output  6  {AF, CF, OF, ZF, SF, PF}, MSB first.

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, r=0, flags=0, slice index=0, internal carry=0.
- Arithmetic: r = a + (b ^ {WIDTH{op}}) + (cin ^ op), truncated to WIDTH bits.
  - Subtract with cin=1 therefore yields a - b - 1.
- Flags:
  - CF = carry-out of bit WIDTH-1, XOR op. For subtract this is the borrow.
  - AF = carry-out of bit 3, XOR op.
  - OF = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - ZF = (r == 0).
  - SF = r[WIDTH-1].
  - PF = 1 when r[7:0] has an even number of ones.
- FSM:
  - IDLE: in_ready=1. When in_valid && in_ready, register a, b, op and carry0 = cin ^ op; set index=0; go to RUN.
  - RUN: in_ready=0. Each cycle, add slice[index] using the registered carry. Write the result bits into r and store the slice carry-out.
    - Capture the carry out of bit 3 in slice 0 for AF. With SLICE=4 this is the slice-0 carry-out.
    - On the last slice (index = NSL-1), capture the carry into and out of the MSB, compute all flags, and go to DONE.
  - DONE: out_valid=1. r and flags are held stable while out_ready=0. When out_ready=1, go to IDLE with out_valid=0.
- Timing:
  - out_valid rises NSL clock edges after the accepting edge.
  - Initiation interval is NSL+2 cycles.
  - No request is accepted in RUN or DONE.
- Input changes while not in IDLE are ignored; operands are registered at acceptance.
- r updates progressively during RUN. It is only defined while out_valid=1.
- A reset during RUN or DONE discards the operation; no output handshake follows.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- Defined:
  - Adds input port sat (1 bit), registered at acceptance.
  - If sat=1 and OF=1, r is clamped to the signed limit: 0x7FFF-style when a[MSB]=0, 0x8000-style when a[MSB]=1.
  - Flags still reflect the unclamped sum, except ZF, SF and PF, which reflect the clamped r.
  - Clamping is applied in the transition to DONE; latency is unchanged.
- Undefined: no sat port; results always wrap.

Decomposition:
- Package addsub_pkg:
  - Flag bit index constants (FLG_AF=5, FLG_CF=4, FLG_OF=3, FLG_ZF=2, FLG_SF=1, FLG_PF=0).
  - Op encoding constants (OP_ADD=0, OP_SUB=1).
  - FSM state enum (IDLE, RUN, DONE).
- One sub-module, addsub_slice: a combinational SLICE-bit ripple adder.
  - Inputs: a, b already inverted, cin.
  - Outputs: sum, cout, carry into its MSB, carry out of bit 3.
  - Instantiated once and reused every RUN cycle.

Test Plan (WIDTH=16, SLICE=4):
- add 0x7FFF + 0x0001, cin=0 -> r=0x8000; AF=1 CF=0 OF=1 ZF=0 SF=1 PF=1; out_valid exactly 4 edges after acceptance.
- sub 0x0000 - 0x0001, cin=0 -> r=0xFFFF; AF=1 CF=1 OF=0 ZF=0 SF=1 PF=1.
- add 0xFFFF + 0x0001 -> r=0x0000; CF=1 ZF=1 AF=1 OF=0 SF=0 PF=1. Then SBB 0x1234 - 0x1234 with cin=1 -> r=0xFFFF, CF=1, ZF=0.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid -> r and flags stable, in_ready=0. Raise out_ready -> next cycle in_ready=1. A second request issued back-to-back is accepted on that cycle and produces correct results.
- Assert rst for 1 cycle during RUN (index 2) -> immediately out_valid=0, in_ready=1; no result delivered. The next request completes normally.
- With ADDSUB_SAT_EN and sat=1: add 0x7FFF + 0x0001 -> r=0x7FFF, OF=1. sub 0x8000 - 0x0001 -> r=0x8000, OF=1.
